// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: FSM state encoding,
// forwarding-select encodings and the NOP instruction word loaded on a flush.
package hazard_pkg;
   typedef enum logic [1:0] {
      INIT   = 2'd0,
      RUN    = 2'd1,
      MDWAIT = 2'd2
   } hz_state_t;

   localparam logic [1:0]  FWD_RF  = 2'b00;
   localparam logic [1:0]  FWD_WB  = 2'b01;
   localparam logic [1:0]  FWD_MEM = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/hazard_fwd.sv
// Operand forwarding select for the E stage; the M-stage result is newer than
// the W-stage result and therefore takes priority.
module hazard_fwd
   import hazard_pkg::*;
(
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE
);
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
         return FWD_MEM;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: NOP-fill after reset, branch flush, load-use bubble,
// multi-cycle stall with timeout, forwarding. Counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MD_TIMEOUT  = 64,
   parameter int INIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        LoadE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        PCSrcE,
   input  logic        MulDivStartE,
   input  logic        MulDivDoneE,
   output logic        EnF,
   output logic        EnD,
   output logic        EnE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        MdTimeout,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
);
   localparam int WCNT_W = $clog2(MD_TIMEOUT) + 1;
   localparam int ICNT_W = $clog2(INIT_CYCLES + 1) + 1;

   hz_state_t         state, state_nxt;
   logic [ICNT_W-1:0] init_cnt, init_cnt_nxt;
   logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              md_timeout_nxt;
   logic              load_use;

   hazard_fwd u_fwd (
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE)
   );

   assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         init_cnt  <= ICNT_W'(INIT_CYCLES);
         wait_cnt  <= '0;
         MdTimeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_cnt  <= init_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
         MdTimeout <= md_timeout_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      init_cnt_nxt   = init_cnt;
      wait_cnt_nxt   = wait_cnt;
      md_timeout_nxt = MdTimeout;
      EnF            = 1'b1;
      EnD            = 1'b1;
      EnE            = 1'b1;
      FlushD         = 1'b0;
      FlushE         = 1'b0;
      FlushM         = 1'b0;
      case (state)
         INIT: begin
            EnF    = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            if (init_cnt <= ICNT_W'(1))
               state_nxt = RUN;
            else
               init_cnt_nxt = init_cnt - ICNT_W'(1);
         end
         RUN: begin
            // A taken branch squashes the younger instructions, so hazards on them are moot
            if (PCSrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else begin
               if (load_use) begin
                  EnF    = 1'b0;
                  EnD    = 1'b0;
                  FlushE = 1'b1;
               end
               if (MulDivStartE) begin
                  state_nxt    = MDWAIT;
                  wait_cnt_nxt = '0;
               end
            end
         end
         MDWAIT: begin
            if (MulDivDoneE) begin
               state_nxt = RUN;
            end else begin
               EnF    = 1'b0;
               EnD    = 1'b0;
               EnE    = 1'b0;
               FlushM = 1'b1;
               if (wait_cnt == WCNT_W'(MD_TIMEOUT - 1)) begin
                  md_timeout_nxt = 1'b1;
                  state_nxt      = RUN;
               end else begin
                  wait_cnt_nxt = wait_cnt + WCNT_W'(1);
               end
            end
         end
         default: state_nxt = INIT;
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (!EnD)
            StallCnt <= StallCnt + 32'd1;
         if ((state == RUN) && (FlushD || FlushE))
            FlushCnt <= FlushCnt + 32'd1;
      end
   end
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_hazard_ctrl;
   localparam int MDT  = 64;
   localparam int INIT = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        LoadE, RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivDoneE;
   logic        EnF, EnD, EnE, FlushD, FlushE, FlushM, MdTimeout;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] StallCnt, FlushCnt;

   hazard_ctrl #(.MD_TIMEOUT(MDT), .INIT_CYCLES(INIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE), .MulDivDoneE(MulDivDoneE),
      .EnF(EnF), .EnD(EnD), .EnE(EnE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MdTimeout(MdTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural reference model ----------------
   // phase: 0 = filling pipeline after reset, 1 = running, 2 = waiting on mul/div
   int          m_phase, m_init_left, m_waited;
   bit          m_to;
   logic [31:0] m_stall, m_flush;
   bit          e_enf, e_end, e_ene, e_fd, e_fe, e_fm;
   logic [1:0]  e_fa, e_fb;

   function automatic logic [1:0] ref_fwd(logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
      return 2'd0;
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_init_left = INIT; m_waited = 0; m_to = 0;
      m_stall = 0; m_flush = 0;
   endfunction

   function automatic void model_eval();
      bit lu;
      lu = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      {e_enf, e_end, e_ene, e_fd, e_fe, e_fm} = 6'b111000;
      e_fa = ref_fwd(Rs1E);
      e_fb = ref_fwd(Rs2E);
      if (m_phase == 0) {e_enf, e_fd, e_fe, e_fm} = 4'b0111;
      else if (m_phase == 1) begin
         if (PCSrcE) {e_fd, e_fe} = 2'b11;
         else if (lu) {e_enf, e_end, e_fe} = 3'b001;
      end else if (!MulDivDoneE) {e_enf, e_end, e_ene, e_fm} = 4'b0001;
   endfunction

   function automatic void model_advance();
      model_eval();
      if (!e_end) m_stall = m_stall + 1;
      if (m_phase == 1 && (e_fd || e_fe)) m_flush = m_flush + 1;
      case (m_phase)
         0: begin
            m_init_left--;
            if (m_init_left <= 0) m_phase = 1;
         end
         1: if (!PCSrcE && MulDivStartE) begin m_phase = 2; m_waited = 0; end
         default: begin
            if (MulDivDoneE) m_phase = 1;
            else begin
               m_waited++;
               if (m_waited == MDT) begin m_to = 1; m_phase = 1; end
            end
         end
      endcase
   endfunction

   function automatic void check_all(string nm);
      model_eval();
      chk({nm, ".EnF"}, 32'(EnF), 32'(e_enf));
      chk({nm, ".EnD"}, 32'(EnD), 32'(e_end));
      chk({nm, ".EnE"}, 32'(EnE), 32'(e_ene));
      chk({nm, ".FlushD"}, 32'(FlushD), 32'(e_fd));
      chk({nm, ".FlushE"}, 32'(FlushE), 32'(e_fe));
      chk({nm, ".FlushM"}, 32'(FlushM), 32'(e_fm));
      chk({nm, ".FwdA"}, 32'(ForwardAE), 32'(e_fa));
      chk({nm, ".FwdB"}, 32'(ForwardBE), 32'(e_fb));
      chk({nm, ".MdTimeout"}, 32'(MdTimeout), 32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
      chk({nm, ".StallCnt"}, StallCnt, m_stall);
      chk({nm, ".FlushCnt"}, FlushCnt, m_flush);
`else
      chk({nm, ".StallCnt"}, StallCnt, 32'd0);
      chk({nm, ".FlushCnt"}, FlushCnt, 32'd0);
`endif
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {LoadE, RegWriteM, RegWriteW, PCSrcE, MulDivStartE, MulDivDoneE} = '0;
   endtask

   task automatic tick_check(string nm);
      @(negedge clk);
      check_all(nm);
   endtask

   task automatic tick_adv();
      @(posedge clk);
      if (reset_n) model_advance();
      #1;
   endtask

   task automatic cycle(string nm);
      tick_check(nm);
      tick_adv();
   endtask

   // called at posedge+1; leaves DUT in RUN after the fill cycles
   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #2;
      check_all("rst");
      chk("rst_mdto", 32'(MdTimeout), 32'd0);
      chk("rst_enf", 32'(EnF), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < INIT; i++) cycle("init");
   endtask

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      bit         loade, rwm, rww, pcsrc;
      bit         x_enf, x_end, x_fd, x_fe;
      logic [1:0] x_fa, x_fb;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{1, 2, 5, 3, 0, 5, 5, 0, 1, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00};
      vt[1] = '{1, 2, 5, 0, 0, 0, 5, 0, 1, 1, 0, 1, 1, 0, 0, 2'b01, 2'b00};
      vt[2] = '{1, 2, 9, 9, 0, 9, 9, 0, 0, 1, 0, 1, 1, 0, 0, 2'b01, 2'b01};
      vt[3] = '{1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00};
      vt[4] = '{1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00};
      vt[5] = '{1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 2'b00, 2'b00};
      vt[6] = '{0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00};
      vt[7] = '{7, 3, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00};
      vt[8] = '{4, 1, 2, 6, 4, 6, 2, 1, 1, 1, 0, 0, 0, 0, 1, 2'b01, 2'b10};
      vt[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 1, 1, 1, 1, 1, 2'b00, 2'b00};
   end

   // ---------------- test sequence ----------------
   initial begin
      set_idle();
      reset_n = 1'b0;
      model_reset();
      @(posedge clk); #1;

      // reset release: two NOP-fill cycles, then RUN defaults
      do_reset();
      tick_check("run0");
      chk("run0_enf", 32'(EnF), 32'd1);
      chk("run0_flushd", 32'(FlushD), 32'd0);
      tick_adv();

      // multi-cycle op finishing after 10 stall cycles
      MulDivStartE = 1'b1;
      cycle("md_start");
      MulDivStartE = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick_check("md_wait");
         chk("md_wait_enf", 32'(EnF), 32'd0);
         chk("md_wait_ene", 32'(EnE), 32'd0);
         tick_adv();
      end
      MulDivDoneE = 1'b1;
      tick_check("md_done");
      chk("md_done_enf", 32'(EnF), 32'd1);
      tick_adv();
      MulDivDoneE = 1'b0;
      tick_check("md_after");
`ifdef HAZARD_PERF_CNT_EN
      chk("md_stallcnt", StallCnt, 32'd10);
`else
      chk("md_stallcnt", StallCnt, 32'd0);
`endif
      tick_adv();

      // combinational vector table in RUN
      foreach (vt[i]) begin
         {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
            {vt[i].rs1d, vt[i].rs2d, vt[i].rs1e, vt[i].rs2e, vt[i].rde, vt[i].rdm, vt[i].rdw};
         {LoadE, RegWriteM, RegWriteW, PCSrcE} = {vt[i].loade, vt[i].rwm, vt[i].rww, vt[i].pcsrc};
         tick_check($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_enf", i), 32'(EnF), 32'(vt[i].x_enf));
         chk($sformatf("vec%0d_end", i), 32'(EnD), 32'(vt[i].x_end));
         chk($sformatf("vec%0d_fd", i), 32'(FlushD), 32'(vt[i].x_fd));
         chk($sformatf("vec%0d_fe", i), 32'(FlushE), 32'(vt[i].x_fe));
         chk($sformatf("vec%0d_fa", i), 32'(ForwardAE), 32'(vt[i].x_fa));
         chk($sformatf("vec%0d_fb", i), 32'(ForwardBE), 32'(vt[i].x_fb));
         tick_adv();
      end
      set_idle();

      // timeout: done never arrives
      MulDivStartE = 1'b1;
      cycle("to_start");
      MulDivStartE = 1'b0;
      for (int i = 0; i < MDT; i++) begin
         tick_check("to_wait");
         chk("to_wait_enf", 32'(EnF), 32'd0);
         chk("to_wait_flag", 32'(MdTimeout), 32'd0);
         tick_adv();
      end
      for (int i = 0; i < 3; i++) begin
         tick_check("to_after");
         chk("to_flag", 32'(MdTimeout), 32'd1);
         chk("to_run_enf", 32'(EnF), 32'd1);
         tick_adv();
      end
      do_reset();

      // done coincides with the last allowed wait cycle: no timeout
      MulDivStartE = 1'b1;
      cycle("dt_start");
      MulDivStartE = 1'b0;
      for (int i = 0; i < MDT - 1; i++) cycle("dt_wait");
      MulDivDoneE = 1'b1;
      cycle("dt_done");
      MulDivDoneE = 1'b0;
      tick_check("dt_after");
      chk("dt_flag", 32'(MdTimeout), 32'd0);
      chk("dt_enf", 32'(EnF), 32'd1);
      tick_adv();

      // reset in the middle of a wait
      MulDivStartE = 1'b1;
      cycle("rw_start");
      MulDivStartE = 1'b0;
      for (int i = 0; i < 5; i++) cycle("rw_wait");
      do_reset();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteM    = 1'($urandom_range(0, 1));
         RegWriteW    = 1'($urandom_range(0, 1));
         PCSrcE       = ($urandom_range(0, 7) == 0);
         MulDivStartE = ($urandom_range(0, 15) == 0);
         LoadE        = !MulDivStartE && ($urandom_range(0, 2) == 0);
         MulDivDoneE  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 599) == 0) do_reset();
         else cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
